vend_channel_ctrl: RTL

//  Parametrised N-channel vending controller: per-channel stock counters, sell/restock modes,

---
 rtl/vend_channel_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/vend_channel_ctrl.sv
// N-channel vending controller: per-channel stock, sell/restock, coin accumulation, vend and change.
// Optional idle-payment timeout enabled by defining VEND_TIMEOUT_EN.
module vend_channel_ctrl #(
  parameter int                        NUM_CH      = 4,
  parameter int                        CNT_W       = 4,
  parameter int                        CAPACITY    = 15,
  parameter int                        INIT_STOCK  = 0,
  parameter int                        PRICE_W     = 6,
  parameter logic [NUM_CH*PRICE_W-1:0] PRICE_LIST  = {6'd5, 6'd4, 6'd3, 6'd2},
  parameter int                        TIMEOUT_CYC = 1000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic [NUM_CH-1:0]         sel,
  input  logic                      confirm,
  input  logic                      cancel,
  input  logic                      coin_vld,
  input  logic [PRICE_W-1:0]        coin_val,
  output logic [NUM_CH*CNT_W-1:0]   stock,
  output logic [PRICE_W-1:0]        due,
  output logic [PRICE_W-1:0]        change,
  output logic [NUM_CH-1:0]         vend,
  output logic                      busy,
  output logic                      err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PAY  = 2'd1;
  localparam logic [1:0] S_VEND = 2'd2;
  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PAID_W = PRICE_W + 1;

  logic [1:0]         state;
  logic [CNT_W-1:0]   stock_mem [NUM_CH];
  logic [IDX_W-1:0]   ch;
  logic [PRICE_W-1:0] price;
  logic [PAID_W-1:0]  paid;

  logic               sel_onehot;
  logic [IDX_W-1:0]   sel_idx;
  logic [CNT_W-1:0]   sel_stock;
  logic [PRICE_W-1:0] sel_price;
  logic [PAID_W:0]    paid_sum;
  logic [PAID_W-1:0]  paid_add;
  logic [PAID_W-1:0]  paid_over;
  logic               paid_enough;
  logic [PRICE_W-1:0] due_calc;
  logic [PRICE_W-1:0] change_vend;
  logic [PRICE_W-1:0] change_refund;
  logic               tmo_hit;
  logic               pay_abort;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_stock_out
      assign stock[gi*CNT_W +: CNT_W] = stock_mem[gi];
    end
  endgenerate

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel[i]) sel_idx = IDX_W'(i);
    end
  end

  assign sel_onehot = $onehot(sel);
  assign sel_stock  = stock_mem[sel_idx];
  assign sel_price  = PRICE_LIST[int'(sel_idx)*PRICE_W +: PRICE_W];

  // Running total saturates at all-ones so a flood of coins cannot wrap back below the price.
  assign paid_sum    = {1'b0, paid} + {2'b00, coin_val};
  assign paid_add    = !coin_vld ? paid : (paid_sum[PAID_W] ? '1 : paid_sum[PAID_W-1:0]);
  assign paid_enough = (paid_add >= {1'b0, price});
  assign due_calc    = paid_enough ? '0 : (price - paid_add[PRICE_W-1:0]);
  assign paid_over   = paid_add - {1'b0, price};
  assign change_vend   = paid_over[PAID_W-1] ? '1 : paid_over[PRICE_W-1:0];
  assign change_refund = paid_add[PAID_W-1]  ? '1 : paid_add[PRICE_W-1:0];

`ifdef VEND_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt;

  assign tmo_hit = (state == S_PAY) && !coin_vld && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if ((state != S_PAY) || coin_vld) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end
`else
  assign tmo_hit = (TIMEOUT_CYC < 0);  // timeout disabled: PAY waits indefinitely
`endif

  assign pay_abort = cancel || tmo_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      ch     <= '0;
      price  <= '0;
      paid   <= '0;
      due    <= '0;
      change <= '0;
      vend   <= '0;
      busy   <= 1'b0;
      err    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) stock_mem[i] <= CNT_W'(INIT_STOCK);
    end else begin
      err  <= 1'b0;
      vend <= '0;
      case (state)
        S_IDLE: begin
          if (confirm && !mode) begin
            if (!sel_onehot || (sel_stock == '0)) begin
              err <= 1'b1;
            end else begin
              ch     <= sel_idx;
              price  <= sel_price;
              paid   <= '0;
              change <= '0;
              due    <= sel_price;
              busy   <= 1'b1;
              state  <= S_PAY;
            end
          end else if (confirm && mode) begin
            if (!sel_onehot || (sel_stock == CNT_W'(CAPACITY))) begin
              err <= 1'b1;
            end else begin
              stock_mem[sel_idx] <= sel_stock + CNT_W'(1);
            end
          end
        end
        S_PAY: begin
          if (pay_abort) begin
            change <= change_refund;
            err    <= tmo_hit;
            paid   <= '0;
            due    <= '0;
            busy   <= 1'b0;
            state  <= S_IDLE;
          end else if (paid_enough) begin
            // vend pulse, stock decrement and change all land on the same edge
            vend[ch]      <= 1'b1;
            stock_mem[ch] <= stock_mem[ch] - CNT_W'(1);
            change        <= change_vend;
            paid          <= '0;
            due           <= '0;
            state         <= S_VEND;
          end else begin
            paid <= paid_add;
            due  <= due_calc;
          end
        end
        S_VEND: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
